pc_update_unit: RTL and testbench



---
 rtl/pc_update_unit_pkg.sv | 15 +
 rtl/pc_target_mux.sv | 40 ++++
 rtl/pc_update_unit.sv | 95 +++++++++
 tb/tb_pc_update_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pc_update_unit_pkg.sv
// Shared definitions for the PC update stage: FSM state encoding and
// address-arithmetic constants.
package pc_update_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HALT  = 2'b01,
    FAULT = 2'b10
  } pc_state_e;

  localparam int unsigned PC_INCREMENT    = 4;
  // Lowest PC bit kept from PC+4 when forming a J-type target.
  localparam int unsigned JUMP_REGION_LSB = 28;

endpackage

// File: rtl/pc_target_mux.sv
// Next-PC target generation and priority select (JR > J > branch > PC+4).
// Purely combinational.
module pc_target_mux
  import pc_update_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_index,
  input  logic                jump_reg,
  input  logic [PC_WIDTH-1:0] reg_target,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                misalign
);

  logic [PC_WIDTH-1:0] br_target;
  logic [PC_WIDTH-1:0] j_target;

  assign pc_plus4  = pc + PC_WIDTH'(PC_INCREMENT);
  assign br_target = pc_plus4 + branch_offset;
  assign misalign  = |reg_target[1:0];

  if (PC_WIDTH > JUMP_REGION_LSB) begin : g_region
    assign j_target = {pc_plus4[PC_WIDTH-1:JUMP_REGION_LSB], jump_index, 2'b00};
  end else begin : g_flat
    assign j_target = {jump_index, 2'b00};
  end

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg)          next_pc = reg_target;
    else if (jump)         next_pc = j_target;
    else if (branch_taken) next_pc = br_target;
  end

endmodule

// File: rtl/pc_update_unit.sv
// Program-counter stage: PC register plus RUN/HALT/FAULT control.
// A misaligned JR freezes the PC at the offending instruction until reset.
module pc_update_unit
  import pc_update_unit_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Stall,
  input  logic                Branch_Taken,
  input  logic [PC_WIDTH-1:0] Branch_Offset,
  input  logic                Jump,
  input  logic [25:0]         Jump_Index,
  input  logic                Jump_Reg,
  input  logic [PC_WIDTH-1:0] Reg_Target,
  input  logic                Halt,
  input  logic                Resume,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PC_Plus4,
  output logic                Halted,
  output logic                Misaligned
);

  if (PC_WIDTH < 28) begin : g_bad_width
    $error("pc_update_unit: PC_WIDTH must be at least 28");
  end
  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_vector
    $error("pc_update_unit: RESET_VECTOR must be 4-byte aligned");
  end

  pc_state_e           state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] next_pc;
  logic                misalign;

  pc_target_mux #(
    .PC_WIDTH(PC_WIDTH)
  ) u_target_mux (
    .pc           (pc_q),
    .branch_taken (Branch_Taken),
    .branch_offset(Branch_Offset),
    .jump         (Jump),
    .jump_index   (Jump_Index),
    .jump_reg     (Jump_Reg),
    .reg_target   (Reg_Target),
    .pc_plus4     (PC_Plus4),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_VECTOR;
      state_q    <= RUN;
      Halted     <= 1'b0;
      Misaligned <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (Stall) begin
            // hold everything
          end else if (Halt) begin
            state_q <= HALT;
            Halted  <= 1'b1;
          end else if (Jump_Reg && misalign) begin
            state_q    <= FAULT;
            Misaligned <= 1'b1;
          end else begin
            pc_q <= next_pc;
          end
        end
        HALT: begin
          if (Resume) begin
            pc_q    <= PC_Plus4;
            state_q <= RUN;
            Halted  <= 1'b0;
          end
        end
        FAULT: begin
          // only reset leaves FAULT
        end
        default: begin
          state_q    <= RUN;
          Halted     <= 1'b0;
          Misaligned <= 1'b0;
        end
      endcase
    end
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed plus randomized check of pc_update_unit against a behavioural
// model of the PC stage.
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall, Branch_Taken, Jump, Jump_Reg, Halt, Resume;
  logic [31:0] Branch_Offset, Reg_Target;
  logic [25:0] Jump_Index;
  logic [31:0] PC, PC_Plus4;
  logic        Halted, Misaligned;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // behavioural model state
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_faulted;

  pc_update_unit #(
    .PC_WIDTH    (32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Stall        (Stall),
    .Branch_Taken (Branch_Taken),
    .Branch_Offset(Branch_Offset),
    .Jump         (Jump),
    .Jump_Index   (Jump_Index),
    .Jump_Reg     (Jump_Reg),
    .Reg_Target   (Reg_Target),
    .Halt         (Halt),
    .Resume       (Resume),
    .PC           (PC),
    .PC_Plus4     (PC_Plus4),
    .Halted       (Halted),
    .Misaligned   (Misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic clear();
    rst = 1'b1; Stall = 1'b0; Branch_Taken = 1'b0; Jump = 1'b0; Jump_Reg = 1'b0;
    Halt = 1'b0; Resume = 1'b0; Branch_Offset = '0; Reg_Target = '0; Jump_Index = '0;
  endtask

  // Update the model from the inputs sampled at this edge.
  task automatic model_edge();
    if (!rst) begin
      m_pc = 32'h0; m_halted = 0; m_faulted = 0;
    end else if (m_faulted) begin
      // frozen
    end else if (m_halted) begin
      if (Resume) begin m_pc = m_pc + 4; m_halted = 0; end
    end else if (Stall) begin
      // hold
    end else if (Halt) begin
      m_halted = 1;
    end else if (Jump_Reg) begin
      if (Reg_Target % 4 != 0) m_faulted = 1;
      else m_pc = Reg_Target;
    end else if (Jump) begin
      m_pc = ((m_pc + 4) & 32'hF000_0000) | (32'(Jump_Index) * 4);
    end else if (Branch_Taken) begin
      m_pc = m_pc + 4 + Branch_Offset;
    end else begin
      m_pc = m_pc + 4;
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".pc"}, PC, m_pc);
    chk({tag, ".pc4"}, PC_Plus4, m_pc + 32'd4);
    chk({tag, ".halted"}, {31'b0, Halted}, {31'b0, m_halted});
    chk({tag, ".misaligned"}, {31'b0, Misaligned}, {31'b0, m_faulted});
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    clear(); Jump_Reg = 1'b1; Reg_Target = tgt; tick("jr_setup");
  endtask

  initial begin
    clear();
    #2;
    // reset then free-run
    rst = 1'b0; tick("reset");
    chk("reset_pc", PC, 32'h0);
    clear();
    tick("run1"); tick("run2"); tick("run3");
    chk("run_pc_c", PC, 32'hC);
    chk("run_pc4_10", PC_Plus4, 32'h10);

    // branch backward then forward
    jr_to(32'h40);
    clear(); Branch_Taken = 1'b1; Branch_Offset = 32'hFFFF_FFF0; tick("br_back");
    chk("br_back_pc", PC, 32'h34);
    Branch_Offset = 32'h10; tick("br_fwd");
    chk("br_fwd_pc", PC, 32'h48);

    // jump within region, then wrap at top of address space
    jr_to(32'h1000_0010);
    clear(); Jump = 1'b1; Jump_Index = 26'h000_0100; tick("jump");
    chk("jump_pc", PC, 32'h1000_0400);
    jr_to(32'hFFFF_FFFC);
    clear(); tick("wrap");
    chk("wrap_pc", PC, 32'h0);

    // stall beats halt and jump
    jr_to(32'h20);
    clear(); Stall = 1'b1; Jump = 1'b1; Halt = 1'b1; Jump_Index = 26'h40;
    for (int unsigned i = 0; i < 3; i++) tick("stall");
    chk("stall_pc", PC, 32'h20);
    chk("stall_halted", {31'b0, Halted}, 32'h0);
    Stall = 1'b0; Halt = 1'b0; tick("stall_release");
    chk("stall_release_pc", PC, 32'h100);

    // halt / resume
    jr_to(32'h80);
    clear(); Halt = 1'b1; Branch_Taken = 1'b1; Branch_Offset = 32'h100; tick("halt");
    chk("halt_flag", {31'b0, Halted}, 32'h1);
    chk("halt_pc", PC, 32'h80);
    Halt = 1'b0; tick("halt_ignore_br");
    chk("halt_ignore_pc", PC, 32'h80);
    clear(); Resume = 1'b1; tick("resume");
    chk("resume_pc", PC, 32'h84);
    chk("resume_halted", {31'b0, Halted}, 32'h0);

    // misaligned JR fault, resume ignored, reset recovers
    jr_to(32'h50);
    clear(); Jump_Reg = 1'b1; Jump = 1'b1; Reg_Target = 32'h0000_0102; tick("fault");
    chk("fault_pc", PC, 32'h50);
    chk("fault_flag", {31'b0, Misaligned}, 32'h1);
    clear(); Resume = 1'b1; tick("fault_resume");
    chk("fault_resume_pc", PC, 32'h50);
    clear(); rst = 1'b0; Resume = 1'b1; tick("fault_reset");
    chk("fault_reset_pc", PC, 32'h0);
    chk("fault_reset_flag", {31'b0, Misaligned}, 32'h0);
    jr_to(32'h200);
    chk("jr_aligned_pc", PC, 32'h200);

    // randomized traffic
    for (int unsigned n = 0; n < 400; n++) begin
      clear();
      rst           = ($urandom_range(63) != 0);
      Stall         = ($urandom_range(7) == 0);
      Halt          = ($urandom_range(15) == 0);
      Resume        = ($urandom_range(3) == 0);
      Jump_Reg      = ($urandom_range(7) == 0);
      Jump          = ($urandom_range(7) == 0);
      Branch_Taken  = ($urandom_range(3) == 0);
      Branch_Offset = {{16{$urandom_range(1) == 1}}, 16'($urandom)} << 2;
      Jump_Index    = 26'($urandom);
      Reg_Target    = $urandom & (($urandom_range(3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
